imem_prog: RTL

//   Parametrised instruction memory for the MIPS fetch stage: synchronous read, 1-cycle latency.

---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_prog_if.sv | 27 ++
 rtl/imem_ram_sp.sv | 27 ++
 rtl/imem_prog.sv | 136 +++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory: init FSM encoding and the boot image.
// The boot image is what the core executes first after every reset.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_BOOT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam int BOOT_LEN = 5;

    function automatic logic [31:0] boot_word(input int unsigned idx);
        logic [31:0] w;
        case (idx)
            0:       w = 32'h01095020;
            1:       w = 32'hAC0A8000;
            2:       w = 32'h8EB10000;
            3:       w = 32'h20040001;
            4:       w = 32'h2005FFFF;
            default: w = 32'h00000000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/imem_prog_if.sv
// Fetch request/response, program-write and init status between the fetch unit and imem_prog.
// The master side is the fetch unit / boot loader; the slave side is the memory.
interface imem_prog_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_adr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_fault;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_adr;
    logic [DATA_W-1:0] prog_data;
    logic              init_done;

    modport master (
        output req_valid, req_adr, prog_we, prog_adr, prog_data,
        input  req_ready, rsp_valid, rsp_data, rsp_fault, init_done
    );

    modport slave (
        input  req_valid, req_adr, prog_we, prog_adr, prog_data,
        output req_ready, rsp_valid, rsp_data, rsp_fault, init_done
    );
endinterface

// File: rtl/imem_ram_sp.sv
// Single-port synchronous RAM: one write or one read per cycle, read data one cycle later.
// Read data holds its value on cycles without a read, so callers can rely on it staying put.
module imem_ram_sp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/imem_prog.sv
// Instruction memory with fetch handshake, fault reporting and a program-write port; 1-cycle fetch latency.
// After reset it clears every word, writes the boot image, then serves fetches (writes stall fetches).
module imem_prog
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    imem_prog_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_fault_q, rsp_fault_d;
    // Selects RAM read data onto rsp_data; cleared on reset and on faulting fetches.
    logic               rsp_src_q, rsp_src_d;

    logic               ram_we;
    logic               ram_re;
    logic [IDX_W-1:0]   ram_addr;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;

    logic               in_ready;
    logic               accept;
    logic               req_ok;
    logic               prog_ok;
    logic [IDX_W-1:0]   req_widx;
    logic [IDX_W-1:0]   prog_widx;

    // Full-width range check so that high address bits never alias onto low words.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] adr);
        return (adr[1:0] == 2'b00) && ((adr >> 2) < ADDR_W'(DEPTH));
    endfunction

    assign req_widx  = bus.req_adr[IDX_W+1:2];
    assign prog_widx = bus.prog_adr[IDX_W+1:2];
    assign req_ok    = addr_ok(bus.req_adr);
    assign prog_ok   = addr_ok(bus.prog_adr);

    assign in_ready      = (state_q == ST_READY);
    assign bus.req_ready = in_ready && !bus.prog_we;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.init_done = in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            idx_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_src_q   <= rsp_src_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rsp_valid_d = 1'b0;
        rsp_fault_d = rsp_fault_q;
        rsp_src_d   = rsp_src_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_addr    = req_widx;
        ram_wdata   = '0;

        case (state_q)
            ST_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = idx_q;
                idx_d    = idx_q + 1'b1;
                if (idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_BOOT;
                    idx_d   = '0;
                end
            end
            ST_BOOT: begin
                ram_we    = 1'b1;
                ram_addr  = idx_q;
                ram_wdata = DATA_W'(boot_word(int'(idx_q)));
                idx_d     = idx_q + 1'b1;
                if (idx_q == IDX_W'(BOOT_LEN - 1)) begin
                    state_d = ST_READY;
                    idx_d   = '0;
                end
            end
            ST_READY: begin
                if (bus.prog_we) begin
                    // Bad program addresses are dropped without any indication.
                    if (prog_ok) begin
                        ram_we    = 1'b1;
                        ram_addr  = prog_widx;
                        ram_wdata = bus.prog_data;
                    end
                end else if (accept) begin
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = !req_ok;
                    rsp_src_d   = req_ok;
                    ram_re      = req_ok;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    imem_ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.rsp_data  = rsp_src_q ? ram_rdata : '0;
endmodule
